bus_dispatch: RTL and testbench

Registered one-to-many bus distributor: the fan-out counterpart to the OR-merged shared bus. It accepts one word per cycle from a single producer over a valid/ready handshake and steers it to one of NB_OUTS destination ports, or to all of them in broadcast mode. Each destination has a one-entry output register with its own valid/ready handshake, so a stalled consumer blocks only traffic addressed to it. It sits between the shared CPU data bus and per-unit input latches: register file write ports, ALU operand latches and I/O registers.

---
 rtl/bus_dispatch.sv | 71 +++++++
 tb/tb_bus_dispatch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dispatch.sv
// One-to-many bus distributor: steers each accepted word into one per-destination
// output register (or all of them on broadcast), each with its own valid/ready.
module bus_dispatch #(
   parameter int BUS_WIDTH = 1,
   parameter int NB_OUTS   = 2,
   parameter int IDX_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic [IDX_WIDTH-1:0] in_dest,
   input  logic                 in_bcast,
   output logic [NB_OUTS-1:0]   out_valid,
   input  logic [NB_OUTS-1:0]   out_ready,
   output logic [BUS_WIDTH-1:0] out_buses [NB_OUTS-1:0],
   output logic                 drop_err,
   output logic [7:0]           drop_count
);

   logic [NB_OUTS-1:0] slot_free;
   logic [NB_OUTS-1:0] dest_sel;
   logic [NB_OUTS-1:0] load_p0;
   logic               dest_legal;
   logic               accept;
   logic               drop_p0;

   // One-hot decode of the destination; an out-of-range index decodes to all zeros.
   always_comb begin
      dest_sel = '0;
      for (int k = 0; k < NB_OUTS; k++)
         dest_sel[k] = (in_dest == IDX_WIDTH'(k));
   end

   assign slot_free  = ~out_valid | out_ready;
   assign dest_legal = |dest_sel;

   always_comb begin
      if (in_bcast)
         in_ready = &slot_free;
      else if (dest_legal)
         in_ready = |(dest_sel & slot_free);
      else
         in_ready = 1'b1;
   end

   assign accept  = in_valid & in_ready;
   assign load_p0 = accept ? (in_bcast ? {NB_OUTS{1'b1}} : dest_sel) : '0;
   assign drop_p0 = accept & ~in_bcast & ~dest_legal;

   // Stage boundary: slot registers and drop bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= '0;
         drop_err   <= 1'b0;
         drop_count <= '0;
         for (int k = 0; k < NB_OUTS; k++)
            out_buses[k] <= '0;
      end else begin
         out_valid <= load_p0 | (out_valid & ~out_ready);
         drop_err  <= drop_p0;
         if (drop_p0 && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
         for (int k = 0; k < NB_OUTS; k++)
            if (load_p0[k])
               out_buses[k] <= in_data;
      end
   end

endmodule

// File: tb/tb_bus_dispatch.sv
// Randomized bench for bus_dispatch with a slot-level behavioural model and directed anchors.
module tb_bus_dispatch;

   localparam int BW = 8;
   localparam int NO = 4;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [BW-1:0] in_data = '0;
   logic [IW-1:0] in_dest = '0;
   logic          in_bcast = 1'b0;
   logic [NO-1:0] out_valid;
   logic [NO-1:0] out_ready = '0;
   logic [BW-1:0] out_buses [NO-1:0];
   logic          drop_err;
   logic [7:0]    drop_count;

   int checks = 0;
   int failures = 0;

   // Model state: which slots hold a word, what they hold, drop status.
   logic [NO-1:0] mv = '0;
   logic [BW-1:0] md [NO];
   logic          me = 1'b0;
   int            mc = 0;

   bus_dispatch #(.BUS_WIDTH(BW), .NB_OUTS(NO), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_dest(in_dest), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_buses(out_buses),
      .drop_err(drop_err), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready();
      logic [NO-1:0] fr;
      fr = ~mv | out_ready;
      if (in_bcast) return &fr;
      if (int'(in_dest) < NO) return fr[in_dest[1:0]];
      return 1'b1;
   endfunction

   task automatic model_clear();
      mv = '0;
      me = 1'b0;
      mc = 0;
      for (int k = 0; k < NO; k++) md[k] = '0;
   endtask

   initial model_clear();

   always @(negedge rst_n) model_clear();

   always @(posedge clk) begin
      logic acc;
      if (!rst_n) begin
         model_clear();
      end else begin
         acc = in_valid && model_ready();
         mv = mv & ~out_ready;
         me = 1'b0;
         if (acc) begin
            if (in_bcast) begin
               mv = '1;
               for (int k = 0; k < NO; k++) md[k] = in_data;
            end else if (int'(in_dest) < NO) begin
               mv[in_dest[1:0]] = 1'b1;
               md[in_dest[1:0]] = in_data;
            end else begin
               me = 1'b1;
               if (mc < 255) mc++;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(model_ready()));
      chk("out_valid", 32'(out_valid), 32'(mv));
      for (int k = 0; k < NO; k++)
         chk($sformatf("out_buses[%0d]", k), 32'(out_buses[k]), 32'(md[k]));
      chk("drop_err", 32'(drop_err), 32'(me));
      chk("drop_count", 32'(drop_count), 32'(mc));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_random(input int n);
      logic hold = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = BW'($urandom);
            in_bcast = ($urandom_range(0, 7) == 0);
            in_dest  = IW'($urandom_range(0, 7));
         end
         out_ready = NO'($urandom);
         @(negedge clk);
         hold = in_valid && !in_ready;
         tick();
      end
      in_valid  = 1'b0;
      in_bcast  = 1'b0;
      out_ready = '0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset drop_count", 32'(drop_count), 32'd0);

      // Unicast to dest 2 with a stalled consumer.
      in_valid = 1'b1; in_dest = 3'd2; in_data = 8'hA5;
      #1 chk("uni ready", 32'(in_ready), 32'd1);
      tick();
      chk("uni out_valid", 32'(out_valid), 32'b0100);
      chk("uni bus2", 32'(out_buses[2]), 32'hA5);
      in_data = 8'h5A;
      #1 chk("blocked ready", 32'(in_ready), 32'd0);
      tick();
      chk("blocked bus2", 32'(out_buses[2]), 32'hA5);
      out_ready = 4'b0100;
      #1 chk("refill ready", 32'(in_ready), 32'd1);
      tick();
      chk("refill bus2", 32'(out_buses[2]), 32'h5A);
      chk("refill out_valid", 32'(out_valid), 32'b0100);

      // Streaming through slot 1 with a consumer that keeps up.
      out_ready = 4'b0010; in_dest = 3'd1;
      for (int i = 1; i <= 3; i++) begin
         in_data = 8'(i);
         #1 chk("stream ready", 32'(in_ready), 32'd1);
         tick();
         chk("stream bus1", 32'(out_buses[1]), 32'(i));
         chk("stream valid1", 32'(out_valid[1]), 32'd1);
      end
      in_valid = 1'b0; out_ready = 4'b1111;
      tick();

      // Broadcast held off by a full slot 3.
      out_ready = '0; in_valid = 1'b1; in_dest = 3'd3; in_data = 8'h11;
      tick();
      in_bcast = 1'b1; in_data = 8'h3C;
      #1 chk("bcast blocked", 32'(in_ready), 32'd0);
      tick();
      chk("bcast hold valid", 32'(out_valid), 32'b1000);
      chk("bcast hold bus3", 32'(out_buses[3]), 32'h11);
      out_ready = 4'b1000;
      #1 chk("bcast ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
      chk("bcast out_valid", 32'(out_valid), 32'hF);
      for (int k = 0; k < NO; k++)
         chk("bcast bus", 32'(out_buses[k]), 32'h3C);
      out_ready = 4'b1111;
      tick();
      out_ready = '0;

      // Single illegal destination.
      in_valid = 1'b1; in_dest = 3'd5; in_data = 8'h99;
      #1 chk("drop ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("drop err", 32'(drop_err), 32'd1);
      chk("drop count1", 32'(drop_count), 32'd1);
      chk("drop out_valid", 32'(out_valid), 32'd0);
      tick();
      chk("drop err low", 32'(drop_err), 32'd0);

      run_random(3000);

      // Saturation of the drop counter.
      in_valid = 1'b1; in_bcast = 1'b0; in_dest = 3'd6;
      repeat (300) tick();
      chk("sat err", 32'(drop_err), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("sat count", 32'(drop_count), 32'd255);

      // Asynchronous reset with slots 0 and 2 full.
      out_ready = 4'b1111;
      tick();
      out_ready = '0; in_valid = 1'b1; in_dest = 3'd0; in_data = 8'h12;
      tick();
      in_dest = 3'd2; in_data = 8'h34;
      tick();
      chk("pre-reset valid", 32'(out_valid), 32'b0101);
      in_dest = 3'd1; in_data = 8'h56;
      #2 rst_n = 1'b0;
      #1;
      chk("async rst valid", 32'(out_valid), 32'd0);
      chk("async rst bus0", 32'(out_buses[0]), 32'd0);
      chk("async rst bus2", 32'(out_buses[2]), 32'd0);
      chk("async rst count", 32'(drop_count), 32'd0);
      tick();
      rst_n = 1'b1; in_valid = 1'b1; in_dest = 3'd0; in_data = 8'h77;
      tick();
      in_valid = 1'b0;
      chk("post-reset bus0", 32'(out_buses[0]), 32'h77);
      chk("post-reset valid", 32'(out_valid), 32'b0001);

      run_random(500);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
